tpu_load_sequencer: RTL and testbench
=====================================

# tpu_load_sequencer

Sequences the serial operand loader of the tinytpu datapath. It accepts X and Y operand bytes from the host pin interface through a valid/ready handshake, serializes them LSB-first onto the loader's `data_in_x`/`data_in_y` lines under `load_en`, and pauses at byte boundaries when the host starves. Once all N·N byte pairs are loaded, it fires the single-cycle `init` that starts the systolic transfer, then reports completion. It sits between the chip-level pin decoder and the input loader.

## Interface
- `D_W`, 8, operand width in bits
- `N`, 2, array dimension; one load = N·N byte pairs
- `XFER_CYC`, N+3, cycles from `init` to transfer complete
- `clk`  in  1  clock
- `rst_n`  in  1  reset: synchronous, active-low; sampled on rising `clk`
- `start`  in  1  begin a load-and-compute job (level, sampled in IDLE only)
- `skip_load`  in  1  with `start`: reuse loaded operands; go straight to INIT
- `in_valid`  in  1  host byte pair valid
- `in_ready`  out  1  sequencer accepts the pair this cycle
- `x_byte`, `y_byte`  in  D_W  operand bytes
- `load_en`  out  1  to loader
- `data_in_x`, `data_in_y`  out  1  serial bits to loader
- `init`  out  1  one-cycle transfer start pulse
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, FETCH, SHIFT, INIT, WAIT, DONE.
- IDLE: on `start` go to FETCH, or to INIT if `skip_load`=1. `start` is ignored outside IDLE.
- FETCH: `in_ready`=1. On `in_valid`, latch both bytes into shift registers, set `load_en`=1, and go to SHIFT.
- SHIFT: `load_en` stays high for exactly D_W consecutive cycles (cycles 0..D_W-1 of the word). Bit k (LSB first) drives `data_in_x/y` in cycle k+1, so the bits lag `load_en` by one cycle. This matches the loader, which enters LOAD one cycle after `load_en` rises.
- Back-to-back words: in word cycle D_W-1, `in_ready`=1. If `in_valid`, the next pair is taken and `load_en` remains high with no gap. Otherwise `load_en` drops and the state returns to FETCH. This pause at a byte boundary is legal because the loader's bit and address counters persist through its IDLE.
- A word counter tracks the pairs sent. After the N·N-th pair's last bit is emitted, go to INIT with one guard cycle so the loader's final write completes.
- INIT: `init`=1 for one cycle, then WAIT.
- WAIT: count XFER_CYC cycles, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Serial lines are 0 whenever no bit is scheduled.

## Timing
- Reset values: state IDLE; `load_en`, `data_in_x/y`, `init`, `done`, `busy`, `in_ready` all 0; all counters 0.
- Reset mid-job: the sequencer abandons the job and takes reset values on the next edge. The chip's loader reset must be asserted together with it; the sequencer does not fix up loader counters.
- Minimum full job (host always valid): 1 (FETCH) + N·N·D_W + 1 bit lag + 1 guard + 1 INIT + XFER_CYC + 1 DONE cycles from `start` sample to `done`.
- `in_ready` is high only in FETCH and in the last SHIFT cycle of a word that is not the final one.
- Word counter width is clog2(N·N+1) with no wrap. Bit counter width is clog2(D_W) and wraps to 0 at the word boundary.

## Structure
- Shared `tpu_pkg` holds the state encodings and the D_W/N defaults also used by the loader and array.
- One natural sub-module: `piso_pair`, a dual D_W-bit parallel-load, LSB-first shift register with the one-cycle output lag.
- Everything else stays in the FSM body.

## Test plan
- N=2, D_W=8, host always valid, X bytes 0x01,0x80,0xA5,0xFF and Y bytes 0x10,0x20,0x30,0x40: `load_en` high for exactly 32 contiguous cycles; the serial streams match LSB-first; `init` pulses once 2 cycles after `load_en` falls; `done` follows XFER_CYC+1 cycles later.
- Host drops `in_valid` for 5 cycles after pair 2: `load_en` low exactly across the gap; the loaded memory contents are identical to the first test.
- `start` with `skip_load`=1: no `load_en`, `init` the cycle after IDLE, then `done`.
- `start` held high through a whole job: exactly one job runs; a second job starts only after IDLE is re-entered.
- `rst_n` low during word 3 bit 4: all outputs 0 on the next edge; `busy`=0; a fresh job then completes correctly with the loader also reset.
- `in_valid` asserted in WAIT: `in_ready` stays 0 and no byte is consumed.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: definitions shared by the tinytpu load sequencer, the loader and the array.
//   TPU_D_W / TPU_N : default operand width and array dimension
//   seq_state_e     : load sequencer state encoding
//   cnt_width()     : counter width helper that never returns zero
package tpu_pkg;

   localparam int TPU_D_W = 8;
   localparam int TPU_N   = 2;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_FETCH = 3'd1,
      SEQ_SHIFT = 3'd2,
      SEQ_INIT  = 3'd3,
      SEQ_WAIT  = 3'd4,
      SEQ_DONE  = 3'd5
   } seq_state_e;

   // clog2 clamped to at least one bit so a degenerate count still gets a register
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_pair.sv
// piso_pair: two D_W-bit parallel-load shift registers emitting LSB first.
// The serial outputs are registered, so bit k of a word appears the cycle after the
// k-th shift cycle; outside shift cycles the serial outputs are driven to 0.
//   clk, rst_n       : clock, synchronous active-low reset
//   load             : capture x_par/y_par (may coincide with the last shift of a word)
//   shift            : move one bit from each register onto the serial outputs
//   x_par, y_par     : parallel operand bytes
//   x_ser, y_ser     : serial bit streams
module piso_pair
   import tpu_pkg::*;
#(
   parameter int D_W = TPU_D_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           shift,
   input  logic [D_W-1:0] x_par,
   input  logic [D_W-1:0] y_par,
   output logic           x_ser,
   output logic           y_ser
);

   logic [D_W-1:0] x_sr_r;
   logic [D_W-1:0] y_sr_r;
   logic           x_ser_r;
   logic           y_ser_r;

   // shift registers with a registered output stage; load wins over shift so that a
   // back-to-back word can be captured while the previous word's last bit goes out
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_sr_r  <= '0;
         y_sr_r  <= '0;
         x_ser_r <= 1'b0;
         y_ser_r <= 1'b0;
      end else begin
         if (load) begin
            x_sr_r <= x_par;
            y_sr_r <= y_par;
         end else if (shift) begin
            x_sr_r <= {1'b0, x_sr_r[D_W-1:1]};
            y_sr_r <= {1'b0, y_sr_r[D_W-1:1]};
         end else begin
            x_sr_r <= x_sr_r;
            y_sr_r <= y_sr_r;
         end
         if (shift) begin
            x_ser_r <= x_sr_r[0];
            y_ser_r <= y_sr_r[0];
         end else begin
            x_ser_r <= 1'b0;
            y_ser_r <= 1'b0;
         end
      end
   end

   assign x_ser = x_ser_r;
   assign y_ser = y_ser_r;

endmodule

// File: rtl/tpu_load_sequencer.sv
// tpu_load_sequencer: feeds host operand byte pairs to the serial operand loader,
// then fires the systolic transfer and reports completion.
//   clk, rst_n           : clock, synchronous active-low reset
//   start, skip_load     : job request (sampled in IDLE); skip_load reuses loaded operands
//   in_valid, in_ready   : host byte-pair handshake
//   x_byte, y_byte       : operand bytes
//   load_en              : loader enable, high for D_W cycles per word
//   data_in_x, data_in_y : serial bits, one cycle behind load_en
//   init                 : one-cycle transfer start pulse
//   busy                 : high outside IDLE
//   done                 : one-cycle end-of-job pulse
// All outputs are registered: the next-state logic also computes next-cycle outputs.
module tpu_load_sequencer
   import tpu_pkg::*;
#(
   parameter int D_W      = TPU_D_W,
   parameter int N        = TPU_N,
   parameter int XFER_CYC = N + 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           skip_load,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [D_W-1:0] x_byte,
   input  logic [D_W-1:0] y_byte,
   output logic           load_en,
   output logic           data_in_x,
   output logic           data_in_y,
   output logic           init,
   output logic           busy,
   output logic           done
);

   localparam int NN   = N * N;
   localparam int BC_W = cnt_width(D_W);
   localparam int WC_W = cnt_width(NN + 1);
   localparam int WT_W = cnt_width(XFER_CYC);

   localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(D_W - 1);
   localparam logic [BC_W-1:0] BIT_PENULT = BC_W'(D_W - 2);
   localparam logic [BC_W-1:0] BC_ONE     = BC_W'(1);
   localparam logic [WC_W-1:0] WORD_LAST  = WC_W'(NN);
   localparam logic [WC_W-1:0] WC_ONE     = WC_W'(1);
   localparam logic [WT_W-1:0] WAIT_LAST  = WT_W'(XFER_CYC - 1);
   localparam logic [WT_W-1:0] WT_ONE     = WT_W'(1);

   // drain phases after the final word: bit-lag cycle, then loader write guard cycle
   localparam logic [1:0] DRAIN_OFF   = 2'd0;
   localparam logic [1:0] DRAIN_LAG   = 2'd1;
   localparam logic [1:0] DRAIN_GUARD = 2'd2;

   seq_state_e      state_r, state_s;
   logic [BC_W-1:0] bit_cnt_r, bit_cnt_s;
   logic [WC_W-1:0] word_cnt_r, word_cnt_s;
   logic [WT_W-1:0] wait_cnt_r, wait_cnt_s;
   logic [1:0]      drain_r, drain_s;
   logic            load_en_r, load_en_s;
   logic            in_ready_r, in_ready_s;
   logic            init_r, init_s;
   logic            done_r, done_s;
   logic            busy_r, busy_s;
   logic            take_s;

   // a pair is consumed only when the registered ready is up, so host sees a clean handshake
   assign take_s = in_ready_r & in_valid;

   // next state, counters and next-cycle output values
   always_comb begin
      state_s    = state_r;
      bit_cnt_s  = bit_cnt_r;
      word_cnt_s = word_cnt_r;
      wait_cnt_s = wait_cnt_r;
      drain_s    = drain_r;
      load_en_s  = 1'b0;
      in_ready_s = 1'b0;
      init_s     = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         SEQ_IDLE: begin
            if (start) begin
               word_cnt_s = '0;
               bit_cnt_s  = '0;
               if (skip_load) begin
                  state_s = SEQ_INIT;
                  init_s  = 1'b1;
               end else begin
                  state_s    = SEQ_FETCH;
                  in_ready_s = 1'b1;
               end
            end else begin
               state_s = SEQ_IDLE;
            end
         end
         SEQ_FETCH: begin
            if (take_s) begin
               state_s    = SEQ_SHIFT;
               load_en_s  = 1'b1;
               bit_cnt_s  = '0;
               word_cnt_s = word_cnt_r + WC_ONE;
            end else begin
               in_ready_s = 1'b1;
            end
         end
         SEQ_SHIFT: begin
            if (drain_r == DRAIN_LAG) begin
               drain_s = DRAIN_GUARD;
            end else if (drain_r != DRAIN_OFF) begin
               drain_s = DRAIN_OFF;
               state_s = SEQ_INIT;
               init_s  = 1'b1;
            end else if (bit_cnt_r != BIT_LAST) begin
               load_en_s  = 1'b1;
               bit_cnt_s  = bit_cnt_r + BC_ONE;
               // open the handshake in the last cycle of every word except the final one
               in_ready_s = (bit_cnt_r == BIT_PENULT) && (word_cnt_r != WORD_LAST);
            end else if (word_cnt_r == WORD_LAST) begin
               bit_cnt_s = '0;
               drain_s   = DRAIN_LAG;
            end else if (take_s) begin
               load_en_s  = 1'b1;
               bit_cnt_s  = '0;
               word_cnt_s = word_cnt_r + WC_ONE;
            end else begin
               // host starved: park at the byte boundary, loader counters hold meanwhile
               bit_cnt_s  = '0;
               state_s    = SEQ_FETCH;
               in_ready_s = 1'b1;
            end
         end
         SEQ_INIT: begin
            state_s    = SEQ_WAIT;
            wait_cnt_s = '0;
         end
         SEQ_WAIT: begin
            if (wait_cnt_r == WAIT_LAST) begin
               state_s    = SEQ_DONE;
               done_s     = 1'b1;
               wait_cnt_s = '0;
            end else begin
               wait_cnt_s = wait_cnt_r + WT_ONE;
            end
         end
         SEQ_DONE: begin
            state_s = SEQ_IDLE;
         end
         default: begin
            state_s    = SEQ_IDLE;
            bit_cnt_s  = '0;
            word_cnt_s = '0;
            wait_cnt_s = '0;
            drain_s    = DRAIN_OFF;
         end
      endcase
      busy_s = (state_s != SEQ_IDLE);
   end

   // state, counter and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= SEQ_IDLE;
         bit_cnt_r  <= '0;
         word_cnt_r <= '0;
         wait_cnt_r <= '0;
         drain_r    <= DRAIN_OFF;
         load_en_r  <= 1'b0;
         in_ready_r <= 1'b0;
         init_r     <= 1'b0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         bit_cnt_r  <= bit_cnt_s;
         word_cnt_r <= word_cnt_s;
         wait_cnt_r <= wait_cnt_s;
         drain_r    <= drain_s;
         load_en_r  <= load_en_s;
         in_ready_r <= in_ready_s;
         init_r     <= init_s;
         done_r     <= done_s;
         busy_r     <= busy_s;
      end
   end

   // shift whenever load_en is high this cycle; serial bits follow one cycle later
   piso_pair #(
      .D_W (D_W)
   ) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (take_s),
      .shift (load_en_r),
      .x_par (x_byte),
      .y_par (y_byte),
      .x_ser (data_in_x),
      .y_ser (data_in_y)
   );

   assign load_en  = load_en_r;
   assign in_ready = in_ready_r;
   assign init     = init_r;
   assign done     = done_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_tpu_load_sequencer.sv
// Directed bench for tpu_load_sequencer (D_W=8, N=2, XFER_CYC=5).
// Cycle c=0 of a job is the IDLE cycle in which start is sampled.
module tb_tpu_load_sequencer;

   localparam int D_W = 8;
   localparam int N   = 2;
   localparam int NN  = N * N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           skip_load;
   logic           in_valid;
   logic           in_ready;
   logic [D_W-1:0] x_byte;
   logic [D_W-1:0] y_byte;
   logic           load_en;
   logic           data_in_x;
   logic           data_in_y;
   logic           init;
   logic           busy;
   logic           done;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] xt [NN] = '{8'h01, 8'h80, 8'hA5, 8'hFF};
   logic [7:0] yt [NN] = '{8'h10, 8'h20, 8'h30, 8'h40};

   // per-job observations
   int r_done_cyc, r_done_cnt, r_init_cyc, r_init_cnt;
   int r_le_cnt, r_le_rise, r_le_first, r_le_last;
   int r_rdy_cnt, r_acc, r_line_err, r_busy_err;
   logic [7:0] mx [NN];
   logic [7:0] my [NN];

   tpu_load_sequencer #(.D_W(D_W), .N(N), .XFER_CYC(N + 3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .skip_load (skip_load),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_byte    (x_byte),
      .y_byte    (y_byte),
      .load_en   (load_en),
      .data_in_x (data_in_x),
      .data_in_y (data_in_y),
      .init      (init),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_load_en"}, int'(load_en), 0);
      chk({tag, "_dx"}, int'(data_in_x), 0);
      chk({tag, "_dy"}, int'(data_in_y), 0);
      chk({tag, "_init"}, int'(init), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
   endtask

   // Runs one job from an IDLE negedge. gap_len>0: hold in_valid low for that many
   // ready cycles once pair 2 is taken, and keep it low after the last pair.
   // gap_len==0: in_valid stays high throughout (junk bytes after the last pair).
   // abort_at>=0: drive rst_n low at that cycle and return.
   task automatic run_job(input bit skip, input bit keep_start, input int gap_len,
                          input int abort_at);
      int   idx = 0;
      int   gap = gap_len;
      int   cap = 0;
      logic prev_le = 1'b0;
      r_done_cyc = -1; r_done_cnt = 0; r_init_cyc = -1; r_init_cnt = 0;
      r_le_cnt = 0; r_le_rise = 0; r_le_first = -1; r_le_last = -1;
      r_rdy_cnt = 0; r_acc = 0; r_line_err = 0; r_busy_err = 0;
      for (int i = 0; i < NN; i++) begin
         mx[i] = 8'h00;
         my[i] = 8'h00;
      end
      start     = 1'b1;
      skip_load = skip;
      for (int c = 0; c < 300; c++) begin
         if (load_en) begin
            r_le_cnt++;
            if (!prev_le) begin
               r_le_rise++;
               if (r_le_first < 0) r_le_first = c;
            end
            r_le_last = c;
         end
         if (prev_le) begin
            if (cap < NN * 8) begin
               mx[cap / 8][cap % 8] = data_in_x;
               my[cap / 8][cap % 8] = data_in_y;
            end
            cap++;
         end else if (data_in_x || data_in_y) begin
            r_line_err++;
         end
         prev_le = load_en;
         if (init) begin
            r_init_cnt++;
            r_init_cyc = c;
         end
         if (busy !== (c != 0)) r_busy_err++;
         if (in_ready) r_rdy_cnt++;
         if (c >= 1) start = keep_start;
         if (skip || idx >= NN) begin
            in_valid = skip || (gap_len == 0);
            x_byte   = 8'hEE;
            y_byte   = 8'hEE;
         end else if (idx == 2 && gap > 0 && in_ready) begin
            in_valid = 1'b0;
            gap--;
         end else begin
            in_valid = 1'b1;
            x_byte   = xt[idx];
            y_byte   = yt[idx];
         end
         if (in_ready && in_valid) begin
            r_acc++;
            if (idx < NN) idx++;
         end
         if (done) begin
            r_done_cnt++;
            r_done_cyc = c;
            break;
         end
         if (c == abort_at) begin
            rst_n = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      skip_load = 1'b0;
      start     = keep_start;
   endtask

   task automatic check_full(input string tag, input int e_done, input int e_init,
                             input int e_le_last, input int e_rise, input int e_rdy);
      chk({tag, "_done_cyc"}, r_done_cyc, e_done);
      chk({tag, "_done_cnt"}, r_done_cnt, 1);
      chk({tag, "_init_cyc"}, r_init_cyc, e_init);
      chk({tag, "_init_cnt"}, r_init_cnt, 1);
      chk({tag, "_le_cnt"}, r_le_cnt, NN * D_W);
      chk({tag, "_le_first"}, r_le_first, 2);
      chk({tag, "_le_last"}, r_le_last, e_le_last);
      chk({tag, "_le_rise"}, r_le_rise, e_rise);
      chk({tag, "_rdy_cnt"}, r_rdy_cnt, e_rdy);
      chk({tag, "_accepted"}, r_acc, NN);
      chk({tag, "_line_idle0"}, r_line_err, 0);
      chk({tag, "_busy"}, r_busy_err, 0);
      for (int i = 0; i < NN; i++) begin
         chk($sformatf("%s_memx%0d", tag, i), int'(mx[i]), int'(xt[i]));
         chk($sformatf("%s_memy%0d", tag, i), int'(my[i]), int'(yt[i]));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      skip_load = 1'b0;
      in_valid  = 1'b0;
      x_byte    = 8'h00;
      y_byte    = 8'h00;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_outputs_zero("idle");

      // host always valid, in_valid also high during WAIT
      run_job(1'b0, 1'b0, 0, -1);
      check_full("full", 42, 36, 33, 1, 4);
      @(negedge clk);

      // 5-cycle host starvation after pair 2
      run_job(1'b0, 1'b0, 5, -1);
      check_full("gap", 47, 41, 38, 2, 9);
      @(negedge clk);

      // skip_load: straight to INIT, host valid ignored
      run_job(1'b1, 1'b0, 0, -1);
      chk("skip_done_cyc", r_done_cyc, 7);
      chk("skip_done_cnt", r_done_cnt, 1);
      chk("skip_init_cyc", r_init_cyc, 1);
      chk("skip_init_cnt", r_init_cnt, 1);
      chk("skip_le_cnt", r_le_cnt, 0);
      chk("skip_rdy_cnt", r_rdy_cnt, 0);
      chk("skip_accepted", r_acc, 0);
      chk("skip_line_idle0", r_line_err, 0);
      chk("skip_busy", r_busy_err, 0);
      @(negedge clk);

      // start held high: one job, IDLE re-entered, then exactly one more job
      run_job(1'b0, 1'b1, 0, -1);
      check_full("held1", 42, 36, 33, 1, 4);
      @(negedge clk);
      chk("held_idle_busy", int'(busy), 0);
      chk("held_idle_ready", int'(in_ready), 0);
      run_job(1'b0, 1'b1, 0, -1);
      check_full("held2", 42, 36, 33, 1, 4);
      start = 1'b0;
      @(negedge clk);

      // reset during word 3 bit 4 (cycle 22)
      run_job(1'b0, 1'b0, 0, 22);
      chk("abort_le_cnt", r_le_cnt, 21);
      @(negedge clk);
      chk_outputs_zero("abort");
      rst_n    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      run_job(1'b0, 1'b0, 0, -1);
      check_full("fresh", 42, 36, 33, 1, 4);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
